mod_barrett_arb: RTL and testbench

MOD_BARRETT_ARB -- requirements
Module: mod_barrett_arb

---
 rtl/pq_mod_pkg.sv | 17 +
 rtl/mod_barrett.sv | 29 ++
 rtl/mod_barrett_arb.sv | 127 ++++++++++++
 tb/tb_mod_barrett_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_mod_pkg.sv
// Shared constants and pipeline entry type for the Barrett modular-add arbiter.
// Used by mod_barrett_arb (optional range check under BARRETT_ARB_RANGE_CHK_EN).
package pq_mod_pkg;

  localparam int PQ_Q         = 251;
  localparam int PQ_K         = 14;
  localparam int PQ_M         = 65;
  localparam int PQ_SUM_BOUND = 59599;
  localparam int PQ_ID_W      = 8;

  typedef struct packed {
    logic [15:0]        data;
    logic [PQ_ID_W-1:0] id;
    logic               err;
  } pq_entry_t;

endpackage

// File: rtl/mod_barrett.sv
// Combinational Barrett reduction of a 16-bit sum modulo PARAM_Q.
// Exact for sums up to PQ_SUM_BOUND; a single conditional subtract finishes the reduction.
module mod_barrett
  import pq_mod_pkg::*;
#(
  parameter int PARAM_Q = PQ_Q,
  parameter int PARAM_K = PQ_K,
  parameter int PARAM_M = PQ_M
) (
  input  logic [15:0] sum_i,
  output logic [15:0] res_o
);

  function automatic logic [15:0] barrett_reduce(input logic [15:0] sum);
    logic [31:0] prod;
    logic [31:0] q_est;
    logic [21:0] u;
    logic [15:0] r;
    prod  = 32'(sum) * 32'(PARAM_M);
    q_est = prod >> PARAM_K;
    u     = 22'(q_est * 32'(PARAM_Q));
    // q_est underestimates the quotient by at most one, so r lies in [0, 2Q)
    r     = sum - u[15:0];
    return (r >= 16'(PARAM_Q)) ? (r - 16'(PARAM_Q)) : r;
  endfunction

  assign res_o = barrett_reduce(sum_i);

endmodule

// File: rtl/mod_barrett_arb.sv
// Round-robin arbiter feeding a two-stage Barrett modular-add pipeline.
// Define BARRETT_ARB_RANGE_CHK_EN to add the res_err range-violation output.
module mod_barrett_arb
  import pq_mod_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PARAM_Q = PQ_Q,
  parameter int PARAM_K = PQ_K,
  parameter int PARAM_M = PQ_M,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [31:0]             res_data,
`ifdef BARRETT_ARB_RANGE_CHK_EN
  output logic                    res_err,
`endif
  output logic [ID_W-1:0]         res_id
);

  pq_entry_t          ent_p1_q, ent_p1_d, ent_p2_q, ent_p2_d;
  logic               vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               s1_load, s2_load, in_fire;
  logic [15:0]        a_sel, b_sel, red_p1;

  function automatic logic sum_over(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s > 17'(PQ_SUM_BOUND);
  endfunction

  always_comb begin
    int idx;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any    = 1'b1;
        gnt_idx    = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign a_sel     = req_a[gnt_idx][15:0];
  assign b_sel     = req_b[gnt_idx][15:0];
  assign s2_load   = !vld_p2_q || res_ready;
  assign s1_load   = !vld_p1_q || s2_load;
  assign in_fire   = gnt_any && s1_load && !reset;
  assign req_ready = reset ? '0 : (grant & {NUM_REQ{s1_load}});

  always_comb begin
    vld_p1_d = vld_p1_q;
    ent_p1_d = ent_p1_q;
    vld_p2_d = vld_p2_q;
    ent_p2_d = ent_p2_q;
    rr_ptr_d = rr_ptr_q;
    // p0 -> p1: granted operands are summed and tagged with their requester
    if (s1_load) begin
      vld_p1_d = gnt_any;
      if (gnt_any) begin
        ent_p1_d.data = a_sel + b_sel;
        ent_p1_d.id   = PQ_ID_W'(gnt_idx);
`ifdef BARRETT_ARB_RANGE_CHK_EN
        ent_p1_d.err  = sum_over(a_sel, b_sel);
`else
        ent_p1_d.err  = 1'b0;
`endif
      end
    end
    if (in_fire) rr_ptr_d = ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
    // p1 -> p2: reduced result replaces the raw sum
    if (s2_load) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        ent_p2_d      = ent_p1_q;
        ent_p2_d.data = red_p1;
      end
    end
  end

  mod_barrett #(
    .PARAM_Q(PARAM_Q),
    .PARAM_K(PARAM_K),
    .PARAM_M(PARAM_M)
  ) u_red (
    .sum_i(ent_p1_q.data),
    .res_o(red_p1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      ent_p1_q <= '0;
      ent_p2_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      ent_p1_q <= ent_p1_d;
      ent_p2_q <= ent_p2_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign res_valid = vld_p2_q;
  assign res_data  = {16'b0, ent_p2_q.data};
  assign res_id    = ent_p2_q.id[ID_W-1:0];
`ifdef BARRETT_ARB_RANGE_CHK_EN
  assign res_err   = ent_p2_q.err;
`endif

endmodule

// File: tb/tb_mod_barrett_arb.sv
// Directed bench for mod_barrett_arb: vector table, round-robin, backpressure, reset mid-flight.
// res_err checks are active when BARRETT_ARB_RANGE_CHK_EN is defined.
module tb_mod_barrett_arb;

  localparam int NUM_REQ = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_a;
  logic [NUM_REQ-1:0][31:0] req_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [31:0]              res_data;
  logic [1:0]               res_id;
`ifdef BARRETT_ARB_RANGE_CHK_EN
  logic                     res_err;
`endif

  mod_barrett_arb #(.NUM_REQ(NUM_REQ)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
`ifdef BARRETT_ARB_RANGE_CHK_EN
    .res_err  (res_err),
`endif
    .res_id   (res_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          chk;
    bit          err;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    bit          chk;
  } sb_t;

  int   n_vec = 0;
  int   n_err = 0;
  bit   sb_en = 1'b0;
  sb_t  exp_q[$];
  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Independent model: plain modulo of the truncated 16-bit sum, pushed per input handshake
  always @(negedge clk) begin
    if (sb_en) begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("sb_extra_result", 32'd1, 32'd0);
        else begin
          sb_t e;
          e = exp_q.pop_front();
          check("sb_id", 32'(res_id), 32'(e.id));
          if (e.chk) check("sb_data", res_data, e.data);
        end
      end
      check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_t e;
          logic [16:0] s;
          s      = 17'(req_a[i][15:0] + req_b[i][15:0]);
          e.id   = i;
          e.data = 32'(s[15:0] % 16'd251);
          e.chk  = (s <= 17'd59599);
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int n;
    @(posedge clk); #1;
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    req_a[v.id]     = v.a;
    req_b[v.id]     = v.b;
    n = 0;
    @(negedge clk);
    while (!req_ready[v.id] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("vec_ready", 32'(req_ready[v.id]), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("vec_not_early", 32'(res_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("vec_valid", 32'(res_valid), 32'd1);
    check("vec_id", 32'(res_id), 32'(v.id));
    if (v.chk) check("vec_data", res_data, v.exp);
`ifdef BARRETT_ARB_RANGE_CHK_EN
    check("vec_err", 32'(res_err), 32'(v.err));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold_data;
    logic [1:0]  hold_id;
    int          cnt;

    vecs[0] = '{0, 32'd200,         32'd100,         32'd49,  1'b1, 1'b0};
    vecs[1] = '{2, 32'd30000,       32'd29599,       32'd112, 1'b1, 1'b0};
    vecs[2] = '{2, 32'd30000,       32'd29600,       32'd0,   1'b0, 1'b1};
    vecs[3] = '{1, 32'd250,         32'd1,           32'd0,   1'b1, 1'b0};
    vecs[4] = '{3, 32'd0,           32'd0,           32'd0,   1'b1, 1'b0};
    vecs[5] = '{1, 32'd1000,        32'd2000,        32'd239, 1'b1, 1'b0};
    vecs[6] = '{3, 32'd250,         32'd0,           32'd250, 1'b1, 1'b0};
    vecs[7] = '{0, 32'd12345,       32'd6789,        32'd58,  1'b1, 1'b0};
    vecs[8] = '{2, 32'hABCD_0005,   32'h1234_0006,   32'd11,  1'b1, 1'b0};
    vecs[9] = '{1, 32'd251,         32'd251,         32'd0,   1'b1, 1'b0};

    reset     = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
`ifdef BARRETT_ARB_RANGE_CHK_EN
    check("rst_res_err", 32'(res_err), 32'd0);
`endif
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_en = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Round robin restarts at requester 0 after reset
    @(posedge clk); #1;
    sb_en = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_en = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i] = 32'(i * 100);
      req_b[i] = 32'd7;
    end
    req_valid = '1;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rr_valid", 32'(res_valid), 32'd1);
      check("rr_id", 32'(res_id), 32'(k % NUM_REQ));
    end

    // Backpressure with continuous requests
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    hold_data = res_data;
    hold_id   = res_id;
    check("bp_valid", 32'(res_valid), 32'd1);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(res_valid), 32'd1);
      check("bp_hold_data", res_data, hold_data);
      check("bp_hold_id", 32'(res_id), 32'(hold_id));
      check("bp_ready_low", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    req_valid = '0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    check("bp_drain_count", 32'(cnt), 32'd2);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with two entries in flight
    req_valid = '1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb_en = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("rst_flight_valid", 32'(res_valid), 32'd0);
    check("rst_flight_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_flight_valid_edge", 32'(res_valid), 32'd0);
    req_valid = '0;
    res_ready = 1'b1;
    reset     = 1'b0;
    sb_en     = 1'b1;
    @(posedge clk); #1;
    req_a[3]  = 32'd100;
    req_b[3]  = 32'd200;
    req_valid = 4'b1000;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd8);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_valid", 32'(res_valid), 32'd1);
    check("post_rst_id", 32'(res_id), 32'd3);
    check("post_rst_data", res_data, 32'd49);
    repeat (2) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
